display_scan_controller: RTL and testbench

//  Sequences a multiplexed NUM_DIGITS x 7-segment display from a single system clock.

---
 rtl/sseg_pkg.sv | 58 +++++
 rtl/hex_to_sseg.sv | 16 +
 rtl/display_scan_controller.sv | 190 +++++++++++++++++++
 tb/tb_display_scan_controller.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
// Latency: none (declarations only).
// Backpressure: not applicable.
package sseg_pkg;

  // Scan sequencer states: dark, anti-ghost blanking, digit shown.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_t;

  // All segments off (pins are active-low).
  localparam logic [6:0] SSEG_OFF = 7'h7F;

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}, for hex digits 0..F.
  localparam logic [6:0] GLYPH_0 = 7'h40;
  localparam logic [6:0] GLYPH_1 = 7'h79;
  localparam logic [6:0] GLYPH_2 = 7'h24;
  localparam logic [6:0] GLYPH_3 = 7'h30;
  localparam logic [6:0] GLYPH_4 = 7'h19;
  localparam logic [6:0] GLYPH_5 = 7'h12;
  localparam logic [6:0] GLYPH_6 = 7'h02;
  localparam logic [6:0] GLYPH_7 = 7'h78;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h10;
  localparam logic [6:0] GLYPH_A = 7'h08;
  localparam logic [6:0] GLYPH_B = 7'h03;
  localparam logic [6:0] GLYPH_C = 7'h46;
  localparam logic [6:0] GLYPH_D = 7'h21;
  localparam logic [6:0] GLYPH_E = 7'h06;
  localparam logic [6:0] GLYPH_F = 7'h0E;

  // Nibble to active-low glyph lookup.
  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0:    g = GLYPH_0;
      4'h1:    g = GLYPH_1;
      4'h2:    g = GLYPH_2;
      4'h3:    g = GLYPH_3;
      4'h4:    g = GLYPH_4;
      4'h5:    g = GLYPH_5;
      4'h6:    g = GLYPH_6;
      4'h7:    g = GLYPH_7;
      4'h8:    g = GLYPH_8;
      4'h9:    g = GLYPH_9;
      4'hA:    g = GLYPH_A;
      4'hB:    g = GLYPH_B;
      4'hC:    g = GLYPH_C;
      4'hD:    g = GLYPH_D;
      4'hE:    g = GLYPH_E;
      default: g = GLYPH_F;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/hex_to_sseg.sv
// Decodes one hex nibble into an active-low 7-segment glyph {g..a}.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows input continuously.
module hex_to_sseg
  import sseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  // Pure table lookup; the glyph set lives in the package.
  always_comb begin
    glyph = hex_glyph(nibble);
  end

endmodule

// File: rtl/display_scan_controller.sv
// Scans NUM_DIGITS 7-segment digits (blank then show per digit) from one clock via a tick prescaler.
// Latency: pins registered, one cycle behind the scan state; first anode BLANK_TICKS*(PRESCALE+1)+2 after enable.
// Backpressure: load is level-sampled; staged value commits only at a frame end or while idle, acked by load_ack.
module display_scan_controller
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int CNT_W       = 20,
  parameter int PRESCALE    = 12_500,
  parameter int SHOW_TICKS  = 3,
  parameter int BLANK_TICKS = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic                    load_ack,
  output logic                    frame_done,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp
);

  localparam int IDX_W     = $clog2(NUM_DIGITS);
  localparam int MAX_TICKS = (SHOW_TICKS > BLANK_TICKS) ? SHOW_TICKS : BLANK_TICKS;
  localparam int PH_W      = $clog2(MAX_TICKS + 1);

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(PRESCALE);
  localparam logic [PH_W-1:0]  SHOW_LAST  = PH_W'(SHOW_TICKS - 1);
  localparam logic [PH_W-1:0]  BLANK_LAST = PH_W'(BLANK_TICKS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  // Prescaler
  logic [CNT_W-1:0] cnt;
  logic             tick;

  // Scan sequencer
  scan_state_t      state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [PH_W-1:0]  phase, phase_nxt;

  // Value registers: staging takes user writes, shadow drives the pins
  logic [4*NUM_DIGITS-1:0] staging, shadow;
  logic [NUM_DIGITS-1:0]   staging_dp, shadow_dp;
  logic                    pending;
  logic                    transfer;

  // Current-digit datapath
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic [6:0]            cur_glyph;
  logic [NUM_DIGITS-1:0] digit_sel;

  // Count only while scanning; tick is registered off the terminal count so the FSM sees a clean 1-cycle enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (!en || state == IDLE) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == CNT_LAST);
      if (cnt == CNT_LAST) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Sequencer state, digit index and per-phase tick counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      phase <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      phase <= phase_nxt;
    end
  end

  // Next-state logic: en low forces dark IDLE from anywhere; otherwise advance on ticks.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    phase_nxt = phase;
    if (!en) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
      phase_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = BLANK;
          idx_nxt   = '0;
          phase_nxt = '0;
        end
        BLANK: begin
          if (tick) begin
            if (phase == BLANK_LAST) begin
              state_nxt = SHOW;
              phase_nxt = '0;
            end else begin
              phase_nxt = phase + PH_W'(1);
            end
          end
        end
        SHOW: begin
          if (tick) begin
            if (phase == SHOW_LAST) begin
              state_nxt = BLANK;
              phase_nxt = '0;
              idx_nxt   = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            end else begin
              phase_nxt = phase + PH_W'(1);
            end
          end
        end
        default: begin
          state_nxt = IDLE;
          idx_nxt   = '0;
          phase_nxt = '0;
        end
      endcase
    end
  end

  // Frame end is the final tick of the last digit's show phase; the panel is about to go dark,
  // which makes it the tear-free moment to swap in a new value.
  assign frame_done = (state == SHOW) && tick && (phase == SHOW_LAST) && (idx == IDX_LAST);
  assign transfer   = pending && (frame_done || state == IDLE);
  assign load_ack   = transfer;

  // Staging captures every load (last write wins); shadow takes the old staging on transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      staging    <= '0;
      staging_dp <= '0;
      shadow     <= '0;
      shadow_dp  <= '0;
      pending    <= 1'b0;
    end else begin
      if (transfer) begin
        shadow    <= staging;
        shadow_dp <= staging_dp;
      end
      if (load) begin
        staging    <= data_in;
        staging_dp <= dp_in;
      end
      if (load) begin
        pending <= 1'b1;
      end else if (transfer) begin
        pending <= 1'b0;
      end
    end
  end

  assign cur_nib   = shadow[{idx, 2'b00} +: 4];
  assign cur_dp    = shadow_dp[idx];
  assign digit_sel = NUM_DIGITS'(1) << idx;

  hex_to_sseg u_hex_to_sseg (
    .nibble (cur_nib),
    .glyph  (cur_glyph)
  );

  // Pin registers follow the current state, so a digit change (idx update) is never seen mid-cycle on the pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= '1;
      seg <= SSEG_OFF;
      dp  <= 1'b1;
    end else if (state == SHOW) begin
      an  <= ~digit_sel;
      seg <= cur_glyph;
      dp  <= ~cur_dp;
    end else begin
      an  <= '1;
      seg <= SSEG_OFF;
      dp  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_display_scan_controller.sv
// Self-checking bench for display_scan_controller with a small timing/handshake reference model.
// Latency: model predicts pin values after every clock edge.
// Backpressure: load pulses are driven directly; acks are predicted by the model.
module tb_display_scan_controller;

  localparam int N      = 4;
  localparam int P      = 3;
  localparam int S      = 2;
  localparam int B      = 1;
  localparam int DIG    = (S + B) * (P + 1);
  localparam int FRAME  = N * DIG;
  localparam int BLANKC = B * (P + 1);

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        load;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic        load_ack;
  logic        frame_done;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  display_scan_controller #(
    .NUM_DIGITS  (N),
    .CNT_W       (20),
    .PRESCALE    (P),
    .SHOW_TICKS  (S),
    .BLANK_TICKS (B)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load       (load),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .load_ack   (load_ack),
    .frame_done (frame_done),
    .an         (an),
    .seg        (seg),
    .dp         (dp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  logic [6:0] glyph_tab [16];

  // Reference model: mk = clock edges since scanning was enabled (-1 while idle).
  int          mk;
  bit          mpend;
  logic [15:0] mstage, mshadow;
  logic [3:0]  mstage_dp, mshadow_dp;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp, e_ack, e_fd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mk = -1; mpend = 0;
    mstage = '0; mshadow = '0; mstage_dp = '0; mshadow_dp = '0;
    e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_ack = 1'b0; e_fd = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    int  kk, u, r, d;
    bit  ack;
    ack = mpend && (mk < 0 || (mk > 0 && mk % FRAME == 0));
    kk  = (mk >= 0) ? mk + 1 : -1;
    e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    if (kk >= 2) begin
      u = kk - 2;
      r = u % DIG;
      d = (u / DIG) % N;
      if (r >= BLANKC) begin
        e_an  = ~(4'b0001 << d);
        e_seg = glyph_tab[mshadow[4*d +: 4]];
        e_dp  = ~mshadow_dp[d];
      end
    end
    if (ack) begin
      mshadow = mstage; mshadow_dp = mstage_dp; mpend = 0;
    end
    if (load) begin
      mstage = data_in; mstage_dp = dp_in; mpend = 1;
    end
    if (!en) mk = -1;
    else if (mk < 0) mk = 0;
    else mk++;
    e_fd  = (mk > 0 && mk % FRAME == 0);
    e_ack = mpend && (mk < 0 || e_fd);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    cyc_n++;
    #1;
    check("an",         32'(an),         32'(e_an));
    check("seg",        32'(seg),        32'(e_seg));
    check("dp",         32'(dp),         32'(e_dp));
    check("load_ack",   32'(load_ack),   32'(e_ack));
    check("frame_done", 32'(frame_done), 32'(e_fd));
  endtask

  task automatic run_to_fd(input int budget, output int acks, output bit seen, output logic ack_at);
    acks = 0; seen = 0; ack_at = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      cyc();
      if (load_ack) acks++;
      if (frame_done) begin
        seen = 1; ack_at = load_ack;
      end
    end
  endtask

  task automatic measure_first(output int first, output logic [6:0] g);
    first = -1; g = 7'h7F;
    for (int i = 0; i < 20 && first < 0; i++) begin
      cyc();
      if (an != 4'hF) begin
        first = i; g = seg;
      end
    end
  endtask

  int         first, t0, period, acks;
  bit         seen;
  logic       ack_at;
  logic [6:0] g, g0;

  initial begin
    glyph_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    rst_n = 1'b0; en = 1'b0; load = 1'b0; data_in = '0; dp_in = '0;
    model_reset();
    #12;
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_dp", 32'(dp), 1);
    check("rst_ack", 32'(load_ack), 0);
    check("rst_fd", 32'(frame_done), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Load 1234 while dark: acked right after capture.
    load = 1'b1; data_in = 16'h1234; dp_in = 4'b0100;
    cyc();
    check("idle_ack", 32'(load_ack), 1);
    load = 1'b0;
    cyc();
    check("idle_ack_once", 32'(load_ack), 0);

    // Enable: digit 0 (nibble 4) appears 6 edges after the enabling edge.
    en = 1'b1;
    measure_first(first, g);
    check("first_an_edge", 32'(first), 6);
    check("first_glyph", 32'(g), 32'h19);

    // Frame period between consecutive frame_done pulses.
    t0 = -1; period = -1;
    for (int i = 0; i < 200 && period < 0; i++) begin
      cyc();
      if (frame_done) begin
        if (t0 < 0) t0 = cyc_n;
        else period = cyc_n - t0;
      end
    end
    check("frame_period", 32'(period), 48);

    // Tear-free update mid-frame.
    for (int i = 0; i < 10; i++) cyc();
    load = 1'b1; data_in = 16'hABCD; dp_in = 4'b0001;
    cyc();
    load = 1'b0;
    run_to_fd(60, acks, seen, ack_at);
    check("tear_fd_seen", 32'(seen), 1);
    check("tear_acks", 32'(acks), 1);
    check("tear_ack_at_fd", 32'(ack_at), 1);
    g0 = 7'h7F;
    for (int i = 0; i < FRAME; i++) begin
      cyc();
      if (an == 4'b1110) g0 = seg;
    end
    check("abcd_digit0", 32'(g0), 32'h21);

    // Back-to-back loads in one frame: single ack, last value shown.
    for (int i = 0; i < 3; i++) cyc();
    load = 1'b1; data_in = 16'h1111; dp_in = 4'b0000;
    cyc();
    load = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    load = 1'b1; data_in = 16'h2222; dp_in = 4'b1010;
    cyc();
    load = 1'b0;
    run_to_fd(60, acks, seen, ack_at);
    check("b2b_fd_seen", 32'(seen), 1);
    check("b2b_acks", 32'(acks), 1);
    g0 = 7'h7F;
    for (int i = 0; i < FRAME; i++) begin
      cyc();
      if (an == 4'b1110) g0 = seg;
    end
    check("b2b_digit0", 32'(g0), 32'h24);

    // Drop en while a digit is shown, then re-enable.
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      cyc();
      if (an != 4'hF) seen = 1;
    end
    check("drop_in_show", 32'(seen), 1);
    en = 1'b0;
    cyc();
    cyc();
    check("drop_dark", 32'(an), 32'hF);
    for (int i = 0; i < 3; i++) cyc();
    en = 1'b1;
    measure_first(first, g);
    check("reenable_first", 32'(first), 6);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) en = ~en;
      load = ($urandom_range(0, 15) == 0);
      data_in = 16'($urandom);
      dp_in = 4'($urandom_range(0, 15));
      cyc();
    end
    load = 1'b0;

    // Asynchronous reset in the middle of a scan.
    en = 1'b1;
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      cyc();
      if (an != 4'hF) seen = 1;
    end
    check("prereset_show", 32'(seen), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_an", 32'(an), 32'hF);
    check("midrst_seg", 32'(seg), 32'h7F);
    check("midrst_dp", 32'(dp), 1);
    check("midrst_ack", 32'(load_ack), 0);
    check("midrst_fd", 32'(frame_done), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 120; i++) begin
      load = ($urandom_range(0, 7) == 0);
      data_in = 16'($urandom);
      dp_in = 4'($urandom_range(0, 15));
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
